slow_waveform_multi: RTL and testbench

- Parametrised multi-channel slow-scroll waveform display for the VGA audio visualiser.
- Each window of 2^DECIM_LOG2 audio samples per channel is reduced to one column value, either peak or mean, and written into a per-channel column store of SCREEN_W entries.
- Column writes sweep left to right and wrap. A freeze input holds the displayed trace.
- Combinational pixel lookup drives colour onto the VGA mixer when the current pixel lies on any channel's trace.

---
 rtl/slow_waveform_multi_if.sv | 39 +++
 rtl/slow_waveform_multi.sv | 147 ++++++++++++++
 tb/tb_slow_waveform_multi.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/slow_waveform_multi_if.sv
// Bus bundle for slow_waveform_multi.
// Groups the control inputs (freeze, reduction mode), the per-channel sample
// and colour buses, the VGA pixel coordinates, and the outputs (column commit
// strobe, write column, RGB).
//   master : drives controls, samples, colours and coordinates; reads outputs.
//   slave  : the display block itself.
// No valid/ready handshake is involved: one sample per channel is taken on
// every clk_sample edge, and col_strobe is a one-cycle pulse that needs no
// acknowledge.
interface slow_waveform_multi_if #(
    parameter int SAMPLE_W = 10,
    parameter int CHANNELS = 2,
    parameter int SCREEN_W = 1280,
    parameter int COORD_W  = 12
);
    localparam int COL_W = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;

    logic                         switch;
    logic                         mode;
    logic [CHANNELS*SAMPLE_W-1:0] wave_sample;
    logic [CHANNELS*12-1:0]       waveform;
    logic [COORD_W-1:0]           VGA_HORZ_COORD;
    logic [COORD_W-1:0]           VGA_VERT_COORD;
    logic                         col_strobe;
    logic [COL_W-1:0]             wr_col;
    logic [3:0]                   VGA_Red_waveform;
    logic [3:0]                   VGA_Green_waveform;
    logic [3:0]                   VGA_Blue_waveform;

    modport master (
        output switch, mode, wave_sample, waveform, VGA_HORZ_COORD, VGA_VERT_COORD,
        input  col_strobe, wr_col, VGA_Red_waveform, VGA_Green_waveform, VGA_Blue_waveform
    );

    modport slave (
        input  switch, mode, wave_sample, waveform, VGA_HORZ_COORD, VGA_VERT_COORD,
        output col_strobe, wr_col, VGA_Red_waveform, VGA_Green_waveform, VGA_Blue_waveform
    );
endinterface

// File: rtl/slow_waveform_multi.sv
// Multi-channel slow-scroll waveform display.
// Every window of 2^DECIM_LOG2 samples per channel is reduced to one column
// value (peak or mean, chosen at the window start) and written into a
// per-channel column store. Columns sweep left to right and wrap. Freeze
// (bus.switch) suppresses writes. A combinational lookup colours the current
// VGA pixel when it lies on any channel's trace; lower channel index wins.
// Ports:
//   clk_sample : sample clock, the only clock
//   reset      : synchronous, active-high
//   bus        : slow_waveform_multi_if.slave (controls, samples, colours,
//                pixel coordinates in; col_strobe, wr_col, RGB out)
module slow_waveform_multi #(
    parameter int SAMPLE_W   = 10,
    parameter int CHANNELS   = 2,
    parameter int DECIM_LOG2 = 6,
    parameter int SCREEN_W   = 1280,
    parameter int SCREEN_H   = 1024,
    parameter int COORD_W    = 12
) (
    input logic                  clk_sample,
    input logic                  reset,
    slow_waveform_multi_if.slave bus
);
    localparam int COL_W = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
    // Mean accumulator is wide enough for a full window of maximal samples.
    localparam int ACC_W = SAMPLE_W + DECIM_LOG2;

    // Window sequencing and per-channel reduction state.
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic [SAMPLE_W-1:0]   peak_q [CHANNELS];
    logic [SAMPLE_W-1:0]   peak_d [CHANNELS];
    logic [ACC_W-1:0]      acc_q  [CHANNELS];
    logic [ACC_W-1:0]      acc_d  [CHANNELS];

    // Column bookkeeping.
    logic [COL_W-1:0]    wr_col_q, wr_col_d;
    logic                col_strobe_q, col_strobe_d;
    logic [SCREEN_W-1:0] valid_q, valid_d;

    // Column store; contents are meaningless until the matching valid bit is set.
    logic [SAMPLE_W-1:0] store_q [CHANNELS][SCREEN_W];

    // Per-channel combinational reduction terms.
    logic [SAMPLE_W-1:0] sample_c [CHANNELS];
    logic [SAMPLE_W-1:0] peak_c   [CHANNELS];
    logic [ACC_W-1:0]    sum_c    [CHANNELS];
    logic [SAMPLE_W-1:0] result_c [CHANNELS];

    logic win_last;
    logic win_mode;
    logic commit;

    always_comb begin
        win_last = (cnt_q == {DECIM_LOG2{1'b1}});
        commit   = win_last && !bus.switch;
        cnt_d    = cnt_q + DECIM_LOG2'(1);

        // Mode is captured on the first sample of a window; using the
        // captured-or-current value keeps the whole window on one mode.
        mode_d   = (cnt_q == '0) ? bus.mode : mode_q;
        win_mode = mode_d;

        for (int k = 0; k < CHANNELS; k++) begin
            sample_c[k] = bus.wave_sample[k*SAMPLE_W +: SAMPLE_W];
            peak_c[k]   = (sample_c[k] > peak_q[k]) ? sample_c[k] : peak_q[k];
            sum_c[k]    = acc_q[k] + ACC_W'(sample_c[k]);
            result_c[k] = win_mode ? SAMPLE_W'(sum_c[k] >> DECIM_LOG2) : peak_c[k];
            // The window result already folds in the last sample, so the
            // reduction registers restart from zero for the next window.
            peak_d[k]   = win_last ? '0 : peak_c[k];
            acc_d[k]    = win_last ? '0 : sum_c[k];
        end

        wr_col_d     = wr_col_q;
        valid_d      = valid_q;
        col_strobe_d = commit;
        if (commit) begin
            wr_col_d          = (wr_col_q == COL_W'(SCREEN_W - 1)) ? '0 : wr_col_q + COL_W'(1);
            valid_d[wr_col_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_sample) begin
        if (reset) begin
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            wr_col_q     <= '0;
            col_strobe_q <= 1'b0;
            valid_q      <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                peak_q[k] <= '0;
                acc_q[k]  <= '0;
            end
        end else begin
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            wr_col_q     <= wr_col_d;
            col_strobe_q <= col_strobe_d;
            valid_q      <= valid_d;
            for (int k = 0; k < CHANNELS; k++) begin
                peak_q[k] <= peak_d[k];
                acc_q[k]  <= acc_d[k];
            end
        end
    end

    // Store has no reset: stale data is hidden by the cleared valid vector.
    always_ff @(posedge clk_sample) begin
        if (!reset && commit) begin
            for (int k = 0; k < CHANNELS; k++) begin
                store_q[k][wr_col_q] <= result_c[k];
            end
        end
    end

    // Pixel lookup.
    logic                x_in;
    logic [COL_W-1:0]    x_col;
    logic [COORD_W-1:0]  y_trace [CHANNELS];
    logic [CHANNELS-1:0] hit;
    logic [11:0]         rgb;

    always_comb begin
        x_in  = (bus.VGA_HORZ_COORD < COORD_W'(SCREEN_W));
        x_col = bus.VGA_HORZ_COORD[COL_W-1:0];
        rgb   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            // Sample 0 sits on the bottom row; SCREEN_H exceeds the sample
            // range so this never underflows, and y >= SCREEN_H never hits.
            y_trace[k] = COORD_W'(SCREEN_H - 1) - COORD_W'(store_q[k][x_col]);
            hit[k]     = x_in && valid_q[x_col] && (bus.VGA_VERT_COORD == y_trace[k]);
        end
        // Walk downwards so the lowest-index hitting channel wins.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                rgb = bus.waveform[k*12 +: 12];
            end
        end
    end

    assign bus.col_strobe         = col_strobe_q;
    assign bus.wr_col             = wr_col_q;
    assign bus.VGA_Red_waveform   = rgb[11:8];
    assign bus.VGA_Green_waveform = rgb[7:4];
    assign bus.VGA_Blue_waveform  = rgb[3:0];
endmodule

// File: tb/tb_slow_waveform_multi.sv
// Directed bench for slow_waveform_multi with a 4-sample window and 8 columns.
module tb_slow_waveform_multi;
    localparam int SAMPLE_W = 10;
    localparam int CHANNELS = 2;
    localparam int SCREEN_W = 8;
    localparam int COORD_W  = 12;

    logic clk = 1'b0;
    logic reset;
    int   n_total = 0;
    int   n_bad   = 0;

    slow_waveform_multi_if #(
        .SAMPLE_W(SAMPLE_W), .CHANNELS(CHANNELS), .SCREEN_W(SCREEN_W), .COORD_W(COORD_W)
    ) bus ();

    slow_waveform_multi #(
        .SAMPLE_W(SAMPLE_W), .CHANNELS(CHANNELS), .DECIM_LOG2(2),
        .SCREEN_W(SCREEN_W), .SCREEN_H(1024), .COORD_W(COORD_W)
    ) dut (
        .clk_sample(clk),
        .reset     (reset),
        .bus       (bus)
    );

    // Clock / reset: long period leaves room for many pixel probes per cycle.
    always #50 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: one sample per channel, then sample outputs 1 time unit after the edge.
    task automatic step(input int s0, input int s1);
        bus.wave_sample = {SAMPLE_W'(s1), SAMPLE_W'(s0)};
        @(posedge clk);
        #1;
    endtask

    // One full window; col_strobe must be low after edges 1..3 and reflect
    // the freeze state after edge 4.
    task automatic win(input string tag, input int a0, input int a1, input int a2,
                       input int a3, input int b);
        step(a0, b);
        chk({tag, ".strobe1"}, 32'(bus.col_strobe), 32'd0);
        step(a1, b);
        chk({tag, ".strobe2"}, 32'(bus.col_strobe), 32'd0);
        step(a2, b);
        chk({tag, ".strobe3"}, 32'(bus.col_strobe), 32'd0);
        step(a3, b);
        chk({tag, ".strobe4"}, 32'(bus.col_strobe), 32'(!bus.switch));
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
        bus.VGA_HORZ_COORD = COORD_W'(x);
        bus.VGA_VERT_COORD = COORD_W'(y);
        #1;
        chk(tag, 32'({bus.VGA_Red_waveform, bus.VGA_Green_waveform, bus.VGA_Blue_waveform}),
            32'(exp));
    endtask

    initial begin
        int nz;
        reset              = 1'b1;
        bus.switch         = 1'b0;
        bus.mode           = 1'b0;
        bus.wave_sample    = '0;
        bus.waveform       = {12'h0F0, 12'hABC};
        bus.VGA_HORZ_COORD = '0;
        bus.VGA_VERT_COORD = '0;

        // Reset state: sweep the whole visible area while reset holds.
        step(0, 0);
        step(0, 0);
        nz = 0;
        for (int x = 0; x < SCREEN_W; x++) begin
            for (int y = 0; y < 1024; y++) begin
                bus.VGA_HORZ_COORD = COORD_W'(x);
                bus.VGA_VERT_COORD = COORD_W'(y);
                #0.01;
                if ({bus.VGA_Red_waveform, bus.VGA_Green_waveform, bus.VGA_Blue_waveform} != 12'h0)
                    nz++;
            end
        end
        chk("reset.pixels_lit", 32'(nz), 32'd0);
        chk("reset.wr_col", 32'(bus.wr_col), 32'd0);
        chk("reset.strobe", 32'(bus.col_strobe), 32'd0);
        reset = 1'b0;

        // Peak window: max of 3,900,7,5 is 900 -> row 123.
        win("peak", 3, 900, 7, 5, 0);
        chk("peak.wr_col", 32'(bus.wr_col), 32'd1);
        pix("peak.pix0_123", 0, 123, 12'hABC);
        pix("peak.ch1_bottom", 0, 1023, 12'h0F0);

        // Mean window: 47 >> 2 = 11 -> row 1012; ch1 mean 4 -> row 1019.
        bus.mode = 1'b1;
        win("mean", 10, 11, 12, 14, 4);
        chk("mean.wr_col", 32'(bus.wr_col), 32'd2);
        pix("mean.pix1_1012", 1, 1012, 12'hABC);
        pix("mean.pix1_1019", 1, 1019, 12'h0F0);
        pix("mean.pix1_123", 1, 123, 12'h000);

        // Mode change mid-window is ignored: peak 100 (row 923), not mean 26.
        bus.mode = 1'b0;
        step(1, 0);
        bus.mode = 1'b1;
        step(2, 0);
        step(3, 0);
        step(100, 0);
        chk("modelatch.strobe", 32'(bus.col_strobe), 32'd1);
        chk("modelatch.wr_col", 32'(bus.wr_col), 32'd3);
        pix("modelatch.peak", 2, 923, 12'hABC);
        pix("modelatch.mean", 2, 997, 12'h000);

        // Reset clears valid bits and column pointer.
        bus.mode = 1'b0;
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        chk("rst2.wr_col", 32'(bus.wr_col), 32'd0);
        chk("rst2.strobe", 32'(bus.col_strobe), 32'd0);
        pix("rst2.pix0_123", 0, 123, 12'h000);

        // Nine windows: pointer 1..7, 0, 1; column 0 ends with 180.
        for (int w = 0; w < 9; w++) begin
            int v;
            v = 100 + 10 * w;
            win($sformatf("sweep%0d", w), v, v, v, v, 1000);
            chk($sformatf("sweep%0d.wr_col", w), 32'(bus.wr_col), 32'((w + 1) % 8));
        end
        pix("sweep.col0_new", 0, 843, 12'hABC);
        pix("sweep.col0_old", 0, 923, 12'h000);
        pix("sweep.col3", 3, 893, 12'hABC);
        pix("sweep.col1", 1, 913, 12'hABC);
        pix("sweep.ch1", 0, 23, 12'h0F0);

        // Out-of-range coordinates never light.
        pix("range.x8", 8, 843, 12'h000);
        pix("range.x8_ch1", 8, 23, 12'h000);
        pix("range.y2047", 0, 2047, 12'h000);
        pix("range.x4095", 4095, 843, 12'h000);

        // Freeze for three windows.
        bus.switch = 1'b1;
        for (int w = 0; w < 3; w++) begin
            int v;
            v = 700 + 50 * w;
            win($sformatf("frz%0d", w), v, v, v, v, 300);
            chk($sformatf("frz%0d.wr_col", w), 32'(bus.wr_col), 32'd1);
        end
        pix("frz.col1_kept", 1, 913, 12'hABC);
        pix("frz.col0_kept", 0, 843, 12'hABC);
        pix("frz.col1_nonew", 1, 323, 12'h000);

        // Release: next window lands at the held column 1.
        bus.switch = 1'b0;
        win("rel", 600, 600, 600, 600, 1000);
        chk("rel.wr_col", 32'(bus.wr_col), 32'd2);
        pix("rel.col1_new", 1, 423, 12'hABC);
        pix("rel.col1_old", 1, 913, 12'h000);

        // Channel priority: both at 500, ch0 red wins.
        bus.waveform = {12'h0F0, 12'hF00};
        win("prio", 500, 500, 500, 500, 500);
        chk("prio.wr_col", 32'(bus.wr_col), 32'd3);
        pix("prio.both", 2, 523, 12'hF00);
        win("split", 500, 500, 500, 500, 400);
        pix("split.ch1", 3, 623, 12'h0F0);
        pix("split.ch0", 3, 523, 12'hF00);

        // Reset mid-window discards the partial window.
        step(900, 900);
        step(900, 900);
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        win("midrst", 5, 5, 5, 5, 6);
        chk("midrst.wr_col", 32'(bus.wr_col), 32'd1);
        pix("midrst.ch0", 0, 1018, 12'hF00);
        pix("midrst.ch1", 0, 1017, 12'h0F0);
        pix("midrst.stale", 0, 123, 12'h000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
